// File: rtl/run_monitor.sv
// run_monitor: sequences a processor run (reset, run, drain) and records
// cycle/write statistics until QUIT_STATE or the watchdog ends it.
module run_monitor #(
    parameter int              DW           = 16,
    parameter int              AW           = 16,
    parameter int              SW           = 5,
    parameter logic [SW-1:0]   QUIT_STATE   = SW'(18),
    parameter int              RESET_CYCLES = 1,
    parameter int              TIMEOUT      = 100000,
    parameter int              CW           = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [SW-1:0] ctrl_state,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] proc_dout,
    input  logic          we,
    output logic          proc_reset,
    output logic          busy,
    output logic          done,
    output logic          timed_out,
    output logic [CW-1:0] cycle_count,
    output logic [CW-1:0] write_count,
    output logic [AW-1:0] last_wr_addr,
    output logic [DW-1:0] last_wr_data
);
    localparam int RCW = RESET_CYCLES > 1 ? $clog2(RESET_CYCLES) : 1;
    localparam logic [CW-1:0] ONES = '1;
    localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, RST, RUN, DRAIN, DONE, TOUT} state_t;

    state_t         state_q, state_d;
    logic [RCW-1:0] rcnt_q, rcnt_d;
    logic [CW-1:0]  cyc_q, cyc_d, wr_q, wr_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  data_q, data_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
            cyc_q   <= '0;
            wr_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            cyc_q   <= cyc_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        cyc_d   = cyc_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        // the QUIT cycle and the drain cycle are both counted like ordinary run cycles
        if (state_q == RUN || state_q == DRAIN) begin
            cyc_d = cyc_q == ONES ? cyc_q : cyc_q + CW'(1);
            if (we) begin
                wr_d   = wr_q == ONES ? wr_q : wr_q + CW'(1);
                addr_d = addr;
                data_d = proc_dout;
            end
        end
        case (state_q)
            IDLE, DONE, TOUT: if (start) begin
                state_d = RST;
                rcnt_d  = RCW'(RESET_CYCLES - 1);
                cyc_d   = '0;
                wr_d    = '0;
                addr_d  = '0;
                data_d  = '0;
            end
            RST:     if (rcnt_q == '0) state_d = RUN;
                     else rcnt_d = rcnt_q - RCW'(1);
            RUN:     state_d = ctrl_state == QUIT_STATE ? DRAIN : cyc_q == TLIM ? TOUT : RUN;
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    assign proc_reset   = state_q == IDLE || state_q == RST || state_q == TOUT;
    assign busy         = state_q == RST || state_q == RUN || state_q == DRAIN;
    assign done         = state_q == DONE;
    assign timed_out    = state_q == TOUT;
    assign cycle_count  = cyc_q;
    assign write_count  = wr_q;
    assign last_wr_addr = addr_q;
    assign last_wr_data = data_q;
endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: randomized and directed runs on two instances (1 and 3 reset
// cycles); a negedge monitor scores each finished run against a queued model.
module tb_run_monitor;
    localparam int T = 8;

    typedef struct {
        int          dut;
        bit          dn;
        logic [31:0] cyc;
        logic [31:0] wr;
        logic [15:0] a;
        logic [15:0] dt;
        int          rcyc;
    } exp_t;

    logic        clk = 0, reset = 1;
    logic        start_w[2];
    logic [4:0]  ctrl;
    logic [15:0] addr, dout;
    logic        we;
    logic        pr_w[2], busy_w[2], done_w[2], to_w[2];
    logic [31:0] cyc_w[2], wr_w[2];
    logic [15:0] la_w[2], ld_w[2];

    exp_t sb[$];
    exp_t last[2];
    bit   hold[2];
    bit   pbusy[2];
    int   rst_c[2], run_c[2];
    int   nchk = 0, nfail = 0;

    bit          qa[1:T+1], wa[1:T+1];
    logic [15:0] aa[1:T+1], da[1:T+1];
    int          sir;

    always #5 clk = ~clk;

    run_monitor #(.RESET_CYCLES(1), .TIMEOUT(T)) u0 (
        .clk(clk), .reset(reset), .start(start_w[0]), .ctrl_state(ctrl), .addr(addr),
        .proc_dout(dout), .we(we), .proc_reset(pr_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .timed_out(to_w[0]), .cycle_count(cyc_w[0]), .write_count(wr_w[0]),
        .last_wr_addr(la_w[0]), .last_wr_data(ld_w[0])
    );

    run_monitor #(.RESET_CYCLES(3), .TIMEOUT(T)) u1 (
        .clk(clk), .reset(reset), .start(start_w[1]), .ctrl_state(ctrl), .addr(addr),
        .proc_dout(dout), .we(we), .proc_reset(pr_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .timed_out(to_w[1]), .cycle_count(cyc_w[1]), .write_count(wr_w[1]),
        .last_wr_addr(la_w[1]), .last_wr_data(ld_w[1])
    );

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic int rcy(input int d);
        return d ? 3 : 1;
    endfunction

    task automatic clear_stim();
        for (int k = 1; k <= T + 1; k++) begin
            qa[k] = 0; wa[k] = 0; aa[k] = '0; da[k] = '0;
        end
        sir = 0;
    endtask

    task automatic fill_rand();
        for (int k = 1; k <= T + 1; k++) begin
            qa[k] = $urandom_range(0, 9) == 0;
            wa[k] = 1'($urandom_range(0, 1));
            aa[k] = 16'($urandom);
            da[k] = 16'($urandom);
        end
        sir = $urandom_range(0, 2) == 0 ? $urandom_range(1, T + 1) : 0;
    endtask

    // run ends on the first QUIT within the watchdog window (plus one drain cycle),
    // otherwise after T cycles; only writes inside that window are counted
    function automatic exp_t model(input int d);
        exp_t e;
        int   n = T;
        e.dn = 0;
        for (int k = 1; k <= T; k++)
            if (qa[k]) begin
                n = k + 1;
                e.dn = 1;
                break;
            end
        e.dut = d; e.cyc = n; e.wr = 0; e.a = 0; e.dt = 0; e.rcyc = rcy(d);
        for (int k = 1; k <= n; k++)
            if (wa[k]) begin
                e.wr++;
                e.a = aa[k];
                e.dt = da[k];
            end
        return e;
    endfunction

    task automatic drive(input int d);
        exp_t e = model(d);
        if (sir > int'(e.cyc)) sir = 0;
        sb.push_back(e);
        @(posedge clk); #1 start_w[d] = 1;
        @(posedge clk); #1 start_w[d] = 0;
        for (int i = 0; i < rcy(d); i++) begin
            ctrl = 5'($urandom); we = 1'($urandom); addr = 16'($urandom); dout = 16'($urandom);
            @(posedge clk); #1;
        end
        for (int k = 1; k <= T + 1; k++) begin
            ctrl = qa[k] ? 5'd18 : 5'($urandom_range(0, 17));
            we = wa[k]; addr = aa[k]; dout = da[k];
            start_w[d] = k == sir;
            @(posedge clk); #1;
        end
        start_w[d] = 0; ctrl = 0;
        repeat (3) begin
            we = 1'($urandom); addr = 16'($urandom); dout = 16'($urandom);
            @(posedge clk); #1;
        end
        we = 0;
    endtask

    task automatic chk_reset_vals(input int d, input string n);
        chk({n, "_proc_reset"}, pr_w[d], 1);
        chk({n, "_busy"}, busy_w[d], 0);
        chk({n, "_done"}, done_w[d], 0);
        chk({n, "_timed_out"}, to_w[d], 0);
        chk({n, "_cycle_count"}, cyc_w[d], 0);
        chk({n, "_write_count"}, wr_w[d], 0);
        chk({n, "_last_addr"}, la_w[d], 0);
        chk({n, "_last_data"}, ld_w[d], 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            chk("exclusive_flags", {done_w[d] && to_w[d], (done_w[d] || to_w[d]) && busy_w[d]}, 0);
            if (busy_w[d]) begin
                if (pr_w[d]) rst_c[d]++;
                else run_c[d]++;
            end else if (pbusy[d] && (done_w[d] || to_w[d])) begin
                if (sb.size() == 0) chk("unexpected_finish", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("dut_id", d, e.dut);
                    chk("done", done_w[d], e.dn);
                    chk("timed_out", to_w[d], !e.dn);
                    chk("proc_reset_end", pr_w[d], !e.dn);
                    chk("cycle_count", cyc_w[d], e.cyc);
                    chk("write_count", wr_w[d], e.wr);
                    chk("last_wr_addr", la_w[d], e.a);
                    chk("last_wr_data", ld_w[d], e.dt);
                    chk("rst_cycles", rst_c[d], e.rcyc);
                    chk("run_low_cycles", run_c[d], e.cyc);
                    last[d] = e;
                    hold[d] = 1;
                end
            end else if ((done_w[d] || to_w[d]) && hold[d]) begin
                chk("hold_cycle_count", cyc_w[d], last[d].cyc);
                chk("hold_write_count", wr_w[d], last[d].wr);
                chk("hold_addr", la_w[d], last[d].a);
                chk("hold_data", ld_w[d], last[d].dt);
            end
            if (!busy_w[d]) begin
                rst_c[d] = 0;
                run_c[d] = 0;
            end
            pbusy[d] = busy_w[d];
        end
    end

    initial begin
        start_w[0] = 0; start_w[1] = 0;
        ctrl = 0; addr = 0; dout = 0; we = 0;
        #3;
        chk_reset_vals(0, "por0");
        chk_reset_vals(1, "por1");
        @(negedge clk) reset = 0;

        clear_stim(); qa[5] = 1; drive(0);
        clear_stim(); wa[2] = 1; aa[2] = 16'h1234; da[2] = 16'h5678; wa[4] = 1;
        wa[6] = 1; aa[6] = 16'h0040; da[6] = 16'hBEEF; qa[7] = 1; drive(0);
        clear_stim(); qa[T+1] = 1; wa[3] = 1; da[3] = 16'hA5A5; drive(0);
        clear_stim(); qa[T] = 1; drive(0);
        clear_stim(); qa[3] = 1; wa[1] = 1; aa[1] = 16'h00FF; da[1] = 16'hCAFE; drive(1);
        clear_stim(); qa[4] = 1; wa[3] = 1; aa[3] = 16'h0011; da[3] = 16'h2222; sir = 2; drive(1);

        @(posedge clk); #1 start_w[0] = 1;
        @(posedge clk); #1 start_w[0] = 0; we = 1; addr = 16'h0ABC; dout = 16'h1111;
        repeat (4) @(posedge clk);
        #1 chk("pre_reset_cycle_count", cyc_w[0], 3);
        #1 reset = 1;
        #1 chk_reset_vals(0, "midrun");
        @(negedge clk) reset = 0; we = 0;
        repeat (3) @(posedge clk);
        #1 chk("idle_busy", busy_w[0], 0);
        chk("idle_proc_reset", pr_w[0], 1);
        fill_rand(); drive(0);

        for (int i = 0; i < 24; i++) begin
            fill_rand();
            drive($urandom_range(0, 1));
        end

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        chk("scoreboard_left", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
